dp_pointer_unit: RTL and testbench

DP_POINTER_UNIT -- requirements
Module: dp_pointer_unit

---
 rtl/dp_pointer_unit_if.sv | 27 ++
 rtl/dp_pointer_unit.sv | 77 +++++++
 tb/tb_dp_pointer_unit.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dp_pointer_unit_if.sv
// Bus bundle for dp_pointer_unit: operation request inputs and pointer/status outputs.
interface dp_pointer_unit_if #(
    parameter int WIDTH = 16
);
    logic             en;
    logic [2:0]       dp_op;
    logic [WIDTH-1:0] dp_load;
    logic [WIDTH-1:0] dp_off;
    logic             err_clr;
    logic [WIDTH-1:0] dp;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    // Requester side: issues operations, observes pointer state.
    modport master (
        output en, dp_op, dp_load, dp_off, err_clr,
        input  dp, empty, full, overflow, underflow
    );

    // Pointer unit side.
    modport slave (
        input  en, dp_op, dp_load, dp_off, err_clr,
        output dp, empty, full, overflow, underflow
    );
endinterface

// File: rtl/dp_pointer_unit.sv
// Bounded pointer register (-1..DEPTH-1, -1 = empty) with inc/dec/load/add/clear
// operations. Out-of-range results are rejected: the pointer holds and a sticky
// overflow/underflow flag records the attempt. Never wraps.
module dp_pointer_unit #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256
) (
    input  logic              CLK,
    input  logic              reset,
    dp_pointer_unit_if.slave  bus
);
    localparam longint MAX_DEPTH = longint'(1) << (WIDTH - 1);

    if (DEPTH < 2 || DEPTH > MAX_DEPTH) begin : g_param_check
        $fatal(1, "dp_pointer_unit: DEPTH must be in 2..2^(WIDTH-1)");
    end

    localparam logic [2:0] OP_INC   = 3'b001;
    localparam logic [2:0] OP_DEC   = 3'b010;
    localparam logic [2:0] OP_LOAD  = 3'b011;
    localparam logic [2:0] OP_ADD   = 3'b100;
    localparam logic [2:0] OP_CLEAR = 3'b101;

    // Candidate arithmetic is one bit wider than the pointer so no operand
    // combination can wrap before the range check.
    localparam logic signed [WIDTH:0] MAX_C  = (WIDTH + 1)'(DEPTH - 1);
    localparam logic signed [WIDTH:0] NEG1_C = '1;
    localparam logic signed [WIDTH:0] ONE_C  = (WIDTH + 1)'(1);

    logic [WIDTH-1:0]        dp_q, dp_d;
    logic                    ovf_q, ovf_d;
    logic                    unf_q, unf_d;
    logic signed [WIDTH:0]   dp_ext, cand;
    logic                    act, ovf_hit, unf_hit;

    assign dp_ext = $signed({dp_q[WIDTH-1], dp_q});

    // Decode the operation into a candidate value and range-check it.
    always_comb begin
        cand = dp_ext;
        act  = 1'b0;
        unique case (bus.dp_op)
            OP_INC:   begin cand = dp_ext + ONE_C; act = 1'b1; end
            OP_DEC:   begin cand = dp_ext - ONE_C; act = 1'b1; end
            OP_LOAD:  begin cand = $signed({bus.dp_load[WIDTH-1], bus.dp_load}); act = 1'b1; end
            OP_ADD:   begin cand = dp_ext + $signed({bus.dp_off[WIDTH-1], bus.dp_off}); act = 1'b1; end
            OP_CLEAR: begin cand = NEG1_C; act = 1'b1; end
            default:  begin cand = dp_ext; act = 1'b0; end
        endcase
        act     = act & bus.en;
        ovf_hit = act && (cand > MAX_C);
        unf_hit = act && (cand < NEG1_C);
        dp_d    = (act && !ovf_hit && !unf_hit) ? cand[WIDTH-1:0] : dp_q;
        // A fresh error on the same edge as err_clr wins over the clear.
        ovf_d   = ovf_hit | (ovf_q & ~bus.err_clr);
        unf_d   = unf_hit | (unf_q & ~bus.err_clr);
    end

    // State registers; synchronous reset discards whatever op is presented.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            dp_q  <= '1;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            dp_q  <= dp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign bus.dp        = dp_q;
    assign bus.empty     = (dp_q == '1);
    assign bus.full      = (dp_q == MAX_C[WIDTH-1:0]);
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
endmodule

// File: tb/tb_dp_pointer_unit.sv
// Scoreboard bench for dp_pointer_unit at WIDTH=16, DEPTH=4.
module tb_dp_pointer_unit;
    localparam int W = 16;
    localparam int D = 4;

    typedef struct packed {
        logic [W-1:0] dp;
        logic         empty;
        logic         full;
        logic         ovf;
        logic         unf;
    } obs_t;

    typedef struct packed {
        bit           rst_n;
        bit           en;
        logic [2:0]   op;
        logic [W-1:0] ld;
        logic [W-1:0] off;
        bit           clr;
        obs_t         ex;
    } step_t;

    logic CLK = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    obs_t sbq[$];

    dp_pointer_unit_if #(.WIDTH(W)) bus_if ();

    dp_pointer_unit #(.WIDTH(W), .DEPTH(D)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    always #5 CLK = ~CLK;

    function automatic obs_t ex(input logic [W-1:0] d, input bit o, input bit u);
        obs_t r;
        r.dp    = d;
        r.empty = (d == 16'hFFFF);
        r.full  = (d == 16'(D - 1));
        r.ovf   = o;
        r.unf   = u;
        return r;
    endfunction

    function automatic step_t st(input bit r, input bit e, input logic [2:0] op,
                                 input logic [W-1:0] ld, input logic [W-1:0] off,
                                 input bit clr, input obs_t x);
        step_t s;
        s.rst_n = r; s.en = e; s.op = op; s.ld = ld; s.off = off; s.clr = clr; s.ex = x;
        return s;
    endfunction

    function automatic obs_t sample();
        obs_t g;
        g = {bus_if.dp, bus_if.empty, bus_if.full, bus_if.overflow, bus_if.underflow};
        return g;
    endfunction

    // Drive one cycle of stimulus and sample just after the active edge.
    task automatic cyc(input step_t s);
        reset          = s.rst_n;
        bus_if.en      = s.en;
        bus_if.dp_op   = s.op;
        bus_if.dp_load = s.ld;
        bus_if.dp_off  = s.off;
        bus_if.err_clr = s.clr;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        step_t s[$];
        obs_t g, e;
        s.push_back(st(0, 0, 3'b000, 0, 0, 0, ex(16'hFFFF, 0, 0)));
        s.push_back(st(0, 1, 3'b001, 0, 0, 1, ex(16'hFFFF, 0, 0)));
        s.push_back(st(1, 0, 3'b000, 0, 0, 0, ex(16'hFFFF, 0, 0)));
        foreach (s[i]) begin
            sbq.push_back(s[i].ex);
            cyc(s[i]);
            g = sample(); e = sbq.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL reset[%0d]: got dp=%h e=%b f=%b o=%b u=%b want dp=%h e=%b f=%b o=%b u=%b",
                         i, g.dp, g.empty, g.full, g.ovf, g.unf, e.dp, e.empty, e.full, e.ovf, e.unf);
            end
        end
    endtask

    task automatic test_inc_full();
        step_t s[$];
        obs_t g, e;
        for (int k = 0; k < 4; k++) s.push_back(st(1, 1, 3'b001, 0, 0, 0, ex(16'(k), 0, 0)));
        s.push_back(st(1, 1, 3'b001, 0, 0, 0, ex(16'd3, 1, 0)));
        foreach (s[i]) begin
            sbq.push_back(s[i].ex);
            cyc(s[i]);
            g = sample(); e = sbq.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL inc_full[%0d]: got dp=%h e=%b f=%b o=%b u=%b want dp=%h e=%b f=%b o=%b u=%b",
                         i, g.dp, g.empty, g.full, g.ovf, g.unf, e.dp, e.empty, e.full, e.ovf, e.unf);
            end
        end
    endtask

    task automatic test_dec_empty();
        step_t s[$];
        obs_t g, e;
        s.push_back(st(0, 0, 3'b000, 0, 0, 0, ex(16'hFFFF, 0, 0)));
        s.push_back(st(1, 1, 3'b010, 0, 0, 0, ex(16'hFFFF, 0, 1)));
        s.push_back(st(1, 1, 3'b000, 0, 0, 1, ex(16'hFFFF, 0, 0)));
        foreach (s[i]) begin
            sbq.push_back(s[i].ex);
            cyc(s[i]);
            g = sample(); e = sbq.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL dec_empty[%0d]: got dp=%h e=%b f=%b o=%b u=%b want dp=%h e=%b f=%b o=%b u=%b",
                         i, g.dp, g.empty, g.full, g.ovf, g.unf, e.dp, e.empty, e.full, e.ovf, e.unf);
            end
        end
    endtask

    task automatic test_load_add();
        step_t s[$];
        obs_t g, e;
        s.push_back(st(1, 1, 3'b011, 16'd2, 0, 0, ex(16'd2, 0, 0)));
        s.push_back(st(1, 1, 3'b100, 0, 16'hFFFD, 0, ex(16'hFFFF, 0, 0)));
        s.push_back(st(1, 1, 3'b100, 0, 16'hFFFF, 0, ex(16'hFFFF, 0, 1)));
        s.push_back(st(1, 1, 3'b100, 0, 16'd5, 0, ex(16'hFFFF, 1, 1)));
        foreach (s[i]) begin
            sbq.push_back(s[i].ex);
            cyc(s[i]);
            g = sample(); e = sbq.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL load_add[%0d]: got dp=%h e=%b f=%b o=%b u=%b want dp=%h e=%b f=%b o=%b u=%b",
                         i, g.dp, g.empty, g.full, g.ovf, g.unf, e.dp, e.empty, e.full, e.ovf, e.unf);
            end
        end
    endtask

    task automatic test_load_bounds();
        step_t s[$];
        obs_t g, e;
        s.push_back(st(1, 1, 3'b000, 0, 0, 1, ex(16'hFFFF, 0, 0)));
        s.push_back(st(1, 1, 3'b011, 16'd4, 0, 0, ex(16'hFFFF, 1, 0)));
        s.push_back(st(1, 1, 3'b011, 16'hFFFE, 0, 0, ex(16'hFFFF, 1, 1)));
        s.push_back(st(1, 1, 3'b011, 16'd1, 0, 0, ex(16'd1, 1, 1)));
        s.push_back(st(1, 1, 3'b101, 0, 0, 0, ex(16'hFFFF, 1, 1)));
        s.push_back(st(1, 1, 3'b000, 0, 0, 1, ex(16'hFFFF, 0, 0)));
        s.push_back(st(1, 1, 3'b101, 0, 0, 0, ex(16'hFFFF, 0, 0)));
        s.push_back(st(1, 1, 3'b011, 16'h8000, 0, 0, ex(16'hFFFF, 0, 1)));
        foreach (s[i]) begin
            sbq.push_back(s[i].ex);
            cyc(s[i]);
            g = sample(); e = sbq.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL load_bounds[%0d]: got dp=%h e=%b f=%b o=%b u=%b want dp=%h e=%b f=%b o=%b u=%b",
                         i, g.dp, g.empty, g.full, g.ovf, g.unf, e.dp, e.empty, e.full, e.ovf, e.unf);
            end
        end
    endtask

    task automatic test_set_wins();
        step_t s[$];
        obs_t g, e;
        s.push_back(st(1, 1, 3'b011, 16'd4, 0, 0, ex(16'hFFFF, 1, 1)));
        s.push_back(st(1, 1, 3'b010, 0, 0, 1, ex(16'hFFFF, 0, 1)));
        s.push_back(st(1, 0, 3'b001, 0, 0, 0, ex(16'hFFFF, 0, 1)));
        s.push_back(st(1, 0, 3'b001, 0, 0, 1, ex(16'hFFFF, 0, 0)));
        s.push_back(st(1, 1, 3'b011, 16'd2, 0, 0, ex(16'd2, 0, 0)));
        s.push_back(st(1, 0, 3'b001, 0, 0, 0, ex(16'd2, 0, 0)));
        s.push_back(st(1, 1, 3'b011, 16'd3, 0, 0, ex(16'd3, 0, 0)));
        s.push_back(st(1, 1, 3'b001, 0, 0, 1, ex(16'd3, 1, 0)));
        foreach (s[i]) begin
            sbq.push_back(s[i].ex);
            cyc(s[i]);
            g = sample(); e = sbq.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL set_wins[%0d]: got dp=%h e=%b f=%b o=%b u=%b want dp=%h e=%b f=%b o=%b u=%b",
                         i, g.dp, g.empty, g.full, g.ovf, g.unf, e.dp, e.empty, e.full, e.ovf, e.unf);
            end
        end
    endtask

    task automatic test_reserved_wide();
        step_t s[$];
        obs_t g, e;
        s.push_back(st(1, 1, 3'b110, 16'd0, 16'd1, 0, ex(16'd3, 1, 0)));
        s.push_back(st(1, 1, 3'b111, 16'd0, 16'd1, 0, ex(16'd3, 1, 0)));
        s.push_back(st(1, 1, 3'b000, 16'd0, 16'd1, 1, ex(16'd3, 0, 0)));
        s.push_back(st(1, 1, 3'b100, 0, 16'h7FFF, 0, ex(16'd3, 1, 0)));
        s.push_back(st(1, 1, 3'b100, 0, 16'hFFFE, 1, ex(16'd1, 0, 0)));
        s.push_back(st(1, 1, 3'b100, 0, 16'h8000, 0, ex(16'd1, 0, 1)));
        s.push_back(st(1, 1, 3'b010, 0, 0, 0, ex(16'd0, 0, 1)));
        foreach (s[i]) begin
            sbq.push_back(s[i].ex);
            cyc(s[i]);
            g = sample(); e = sbq.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL reserved_wide[%0d]: got dp=%h e=%b f=%b o=%b u=%b want dp=%h e=%b f=%b o=%b u=%b",
                         i, g.dp, g.empty, g.full, g.ovf, g.unf, e.dp, e.empty, e.full, e.ovf, e.unf);
            end
        end
    endtask

    task automatic test_reset_mid();
        step_t s[$];
        obs_t g, e;
        s.push_back(st(1, 1, 3'b011, 16'd2, 0, 0, ex(16'd2, 0, 1)));
        s.push_back(st(0, 1, 3'b001, 0, 0, 0, ex(16'hFFFF, 0, 0)));
        s.push_back(st(1, 1, 3'b010, 0, 0, 0, ex(16'hFFFF, 0, 1)));
        s.push_back(st(0, 1, 3'b010, 0, 0, 0, ex(16'hFFFF, 0, 0)));
        s.push_back(st(1, 1, 3'b001, 0, 0, 0, ex(16'd0, 0, 0)));
        foreach (s[i]) begin
            sbq.push_back(s[i].ex);
            cyc(s[i]);
            g = sample(); e = sbq.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL reset_mid[%0d]: got dp=%h e=%b f=%b o=%b u=%b want dp=%h e=%b f=%b o=%b u=%b",
                         i, g.dp, g.empty, g.full, g.ovf, g.unf, e.dp, e.empty, e.full, e.ovf, e.unf);
            end
        end
    endtask

    // Random ops against an integer-domain reference; results pushed at drive time.
    task automatic test_random();
        int    mdp = 0;
        bit    mo = 0, mu = 0;
        int    cand;
        step_t s;
        obs_t  g, e;
        for (int i = 0; i < 400; i++) begin
            s.rst_n = ($urandom_range(0, 29) != 0);
            s.en    = ($urandom_range(0, 7) != 0);
            s.op    = 3'($urandom_range(0, 7));
            s.clr   = ($urandom_range(0, 9) == 0);
            s.ld    = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'(int'($urandom_range(0, 8)) - 3);
            s.off   = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'(int'($urandom_range(0, 10)) - 5);
            if (!s.rst_n) begin
                mdp = -1; mo = 0; mu = 0;
            end else begin
                if (s.clr) begin mo = 0; mu = 0; end
                if (s.en && s.op >= 3'd1 && s.op <= 3'd5) begin
                    case (s.op)
                        3'd1:    cand = mdp + 1;
                        3'd2:    cand = mdp - 1;
                        3'd3:    cand = int'($signed(s.ld));
                        3'd4:    cand = mdp + int'($signed(s.off));
                        default: cand = -1;
                    endcase
                    if (cand > D - 1)   mo = 1;
                    else if (cand < -1) mu = 1;
                    else                mdp = cand;
                end
            end
            s.ex = ex(16'(mdp), mo, mu);
            sbq.push_back(s.ex);
            cyc(s);
            g = sample(); e = sbq.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL random[%0d]: got dp=%h e=%b f=%b o=%b u=%b want dp=%h e=%b f=%b o=%b u=%b",
                         i, g.dp, g.empty, g.full, g.ovf, g.unf, e.dp, e.empty, e.full, e.ovf, e.unf);
            end
        end
    endtask

    initial begin
        reset          = 1'b0;
        bus_if.en      = 1'b0;
        bus_if.dp_op   = 3'b000;
        bus_if.dp_load = '0;
        bus_if.dp_off  = '0;
        bus_if.err_clr = 1'b0;
        @(posedge CLK);
        #1;
        test_reset();
        test_inc_full();
        test_dec_empty();
        test_load_add();
        test_load_bounds();
        test_set_wins();
        test_reserved_wide();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
